hls_perf_monitor: RTL and testbench
===================================

# hls_perf_monitor

Synthesisable, parametrised per-module transaction monitor for HLS-generated designs. Watches the block-level handshake (ap_start/ap_done/ap_continue) and a loop-iteration strobe on NUM_CH monitored modules. Measures per-transaction latency and iteration count, and streams one record per completed transaction through a shared FIFO. It generalises the simulation-only module/loop status dumpers to N channels, in hardware, with backpressure and overflow reporting.

## Interface
- NUM_CH, 4: number of monitored modules (1..16).
- CNT_W, 16: width of the latency, iteration and transaction counters.
- DEPTH, 8: record FIFO depth (power of 2, ≥2).
- CH_W, derived, max(1,$clog2(NUM_CH)): channel index width.
- REC_W, derived, CH_W+2*CNT_W+1: record width.

- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  when 0, no new transaction is accepted; in-flight transactions complete normally.
- clear  in  1  synchronous clear of counters, holds, FIFO and overflow; wins over all other events.
- mon_start  in  NUM_CH  ap_start of each monitored module.
- mon_done  in  NUM_CH  ap_done of each monitored module.
- mon_continue  in  NUM_CH  ap_continue; tie to 1 for modules without one.
- mon_iter  in  NUM_CH  one-cycle loop iteration-end strobe (iter_end_state & ~subdone_block & iter_end_enable).
- rec_valid  out  1  FIFO non-empty.
- rec_ready  in  1  consumer accept.
- rec_data  out  REC_W  {ch, latency, iterations, sat}, ch in the MSBs; sat is the LSB.
- txn_count  out  NUM_CH*CNT_W  completed transactions per channel, saturating.
- busy  out  NUM_CH  channel FSM not in IDLE.
- overflow  out  NUM_CH  sticky: a record was dropped on that channel.

## Operation
- Reset values: all FSMs IDLE, every counter 0, holds empty, FIFO empty. rec_valid=0, rec_data=0, busy=0, overflow=0, txn_count=0.
- Per-channel FSM:
  - IDLE → BUSY on mon_start & enable. Loads lat=1 and iter=mon_iter.
  - BUSY: each cycle lat+=1 and iter+=mon_iter, both saturating at 2^CNT_W−1. Saturation sets that transaction's sat bit.
  - BUSY on mon_done: captures the record, using values that include the done cycle. Goes to IDLE if mon_continue, else to WAIT_CONT.
  - WAIT_CONT → IDLE on mon_continue.
  - Done in the start cycle (IDLE with start & done): record captured with lat=1; FSM moves straight to IDLE/WAIT_CONT.
- Overlap: mon_start in BUSY or WAIT_CONT is ignored. This is non-overlapped latency mode only.
- mon_done in IDLE is ignored.
- Each completion increments txn_count[ch], saturating.
- Each channel has a one-entry hold register.
  - Capture with the hold full and not granted this cycle: record dropped, overflow[ch] set.
  - Capture in the cycle the hold is granted: the new record replaces it, no overflow.
- Round-robin arbiter: grants at most one full hold per cycle into the FIFO, only when FIFO count < DEPTH.
  - The pointer advances to granted+1.
  - A pop in the same cycle does not free a slot for a push.
- FIFO is show-ahead: rec_data is valid whenever rec_valid is high. Pop on rec_valid & rec_ready.
- clear: returns FSMs to IDLE and zeroes everything, including overflow and txn_count. A mid-transaction clear discards that transaction.
- Asynchronous reset mid-operation: same result as clear, immediately.

## Timing
- Done sampled in cycle T → hold full in T+1 → FIFO write at end of T+1 if granted → rec_valid in T+2 when the FIFO was empty. Minimum done-to-record latency is 2 cycles.
- busy rises the cycle after start is accepted and falls the cycle after the exit to IDLE.
- overflow rises the cycle after the dropped capture.
- txn_count updates the cycle after done.
- Throughput: one record per cycle sustained.
- No combinational path from any input to any output.

## Structure
- Package hls_perf_pkg holds:
  - state enum {IDLE, BUSY, WAIT_CONT};
  - the record struct typedef, parametrised through localparams;
  - a sat_inc function.
- Sub-module hls_perf_chan holds one channel's FSM, counters and hold register, instantiated NUM_CH times in a generate.
- Arbiter and FIFO stay in the top level.

## Test plan
- Single transaction, ch0: start at cycle 10, done at 17, continue=1, 5 iter strobes → record {0, 8, 5, 0}; rec_valid at 19; txn_count[0]=1.
- Simultaneous done on ch1 and ch3, pointer at 0, rec_ready=1 → ch1 record then ch3 on consecutive cycles.
- CNT_W=4, busy 20 cycles → latency 15, sat=1.
- rec_ready=0, DEPTH=8, ch0 completes 10 back-to-back 2-cycle transactions → 8 in FIFO; hold full; overflow[0]=1 after the 10th; draining yields 9 records.
- continue=0 after done → FSM stays WAIT_CONT and ignores start; continue=1 → IDLE next cycle; next start accepted.
- ap_rst_n pulsed low mid-BUSY with 3 records queued → all outputs 0 immediately; no stale record after release.

Source files
------------

// File: rtl/hls_perf_pkg.sv
// ============================================================================
// hls_perf_pkg : shared types and helpers for the HLS transaction monitor
// Rev 1.0
// ============================================================================
`default_nettype none

package hls_perf_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    WAIT_CONT = 2'd2
  } state_t;

  // Record layout for the default configuration; the RTL packs the same
  // field order into flat vectors so other widths work too.
  localparam int unsigned REC_CH_W  = 2;
  localparam int unsigned REC_CNT_W = 16;

  typedef struct packed {
    logic [REC_CH_W-1:0]  ch;
    logic [REC_CNT_W-1:0] lat;
    logic [REC_CNT_W-1:0] iter;
    logic                 sat;
  } rec_t;

  // Increment v by inc, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc,
                                          input int unsigned w);
    logic [31:0] maxv;
    maxv = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (inc && (v != maxv)) ? v + 32'd1 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hls_perf_chan.sv
// ============================================================================
// hls_perf_chan : one channel's handshake FSM, counters and record hold
// Rev 1.0
// ============================================================================
`default_nettype none

module hls_perf_chan
  import hls_perf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic               i_start,
  input  logic               i_done,
  input  logic               i_cont,
  input  logic               i_iter,
  input  logic               i_grant,
  output logic               o_hold_valid,
  output logic [2*CNT_W:0]   o_hold_rec,
  output logic [CNT_W-1:0]   o_txn,
  output logic               o_busy,
  output logic               o_overflow
);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_lat, r_iter, r_txn, w_lat_nxt, w_iter_nxt, w_lat_inc, w_iter_inc;
  logic               r_sat, w_sat_nxt, w_capture;
  logic               r_hold_full, r_ovf;
  logic [2*CNT_W:0]   r_hold;

  assign w_lat_inc  = CNT_W'(sat_inc(32'(r_lat), 1'b1, CNT_W));
  assign w_iter_inc = CNT_W'(sat_inc(32'(r_iter), i_iter, CNT_W));

  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat;
    w_iter_nxt  = r_iter;
    w_sat_nxt   = r_sat;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && i_enable) begin
          w_lat_nxt  = CNT_W'(1);
          w_iter_nxt = CNT_W'(i_iter);
          w_sat_nxt  = 1'b0;
          if (i_done) begin
            w_capture   = 1'b1;
            w_state_nxt = i_cont ? IDLE : WAIT_CONT;
          end else begin
            w_state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        // sat flags an increment that could not be applied
        w_lat_nxt  = w_lat_inc;
        w_iter_nxt = w_iter_inc;
        w_sat_nxt  = r_sat | (&r_lat) | (i_iter & (&r_iter));
        if (i_done) begin
          w_capture   = 1'b1;
          w_state_nxt = i_cont ? IDLE : WAIT_CONT;
        end
      end
      WAIT_CONT: begin
        if (i_cont) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lat       <= '0;
      r_iter      <= '0;
      r_sat       <= 1'b0;
      r_txn       <= '0;
      r_hold_full <= 1'b0;
      r_hold      <= '0;
      r_ovf       <= 1'b0;
    end else if (i_clear) begin
      r_state     <= IDLE;
      r_lat       <= '0;
      r_iter      <= '0;
      r_sat       <= 1'b0;
      r_txn       <= '0;
      r_hold_full <= 1'b0;
      r_hold      <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lat   <= w_lat_nxt;
      r_iter  <= w_iter_nxt;
      r_sat   <= w_sat_nxt;
      r_txn   <= CNT_W'(sat_inc(32'(r_txn), w_capture, CNT_W));
      // A hold being drained this cycle can take the new record in its place
      if (w_capture) begin
        if (r_hold_full && !i_grant) begin
          r_ovf <= 1'b1;
        end else begin
          r_hold      <= {w_lat_nxt, w_iter_nxt, w_sat_nxt};
          r_hold_full <= 1'b1;
        end
      end else if (i_grant) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  assign o_hold_valid = r_hold_full;
  assign o_hold_rec   = r_hold;
  assign o_txn        = r_txn;
  assign o_busy       = (r_state != IDLE);
  assign o_overflow   = r_ovf;

endmodule

`default_nettype wire

// File: rtl/hls_perf_monitor.sv
// ============================================================================
// hls_perf_monitor : N-channel HLS transaction monitor with record FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module hls_perf_monitor
  import hls_perf_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 16,
  parameter  int DEPTH  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int REC_W  = CH_W + 2*CNT_W + 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       mon_start,
  input  logic [NUM_CH-1:0]       mon_done,
  input  logic [NUM_CH-1:0]       mon_continue,
  input  logic [NUM_CH-1:0]       mon_iter,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [REC_W-1:0]        rec_data,
  output logic [NUM_CH*CNT_W-1:0] txn_count,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [NUM_CH-1:0] w_req, w_grant;
  logic [2*CNT_W:0]  w_hold_rec [NUM_CH];
  logic [REC_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic [CH_W-1:0]   r_rr_ptr, w_gnt_idx;
  logic              w_push, w_pop, w_space;
  int                w_idx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    hls_perf_chan #(.CNT_W(CNT_W)) u_chan (
      .clk          (ap_clk),
      .rst_n        (ap_rst_n),
      .i_clear      (clear),
      .i_enable     (enable),
      .i_start      (mon_start[g]),
      .i_done       (mon_done[g]),
      .i_cont       (mon_continue[g]),
      .i_iter       (mon_iter[g]),
      .i_grant      (w_grant[g]),
      .o_hold_valid (w_req[g]),
      .o_hold_rec   (w_hold_rec[g]),
      .o_txn        (txn_count[g*CNT_W +: CNT_W]),
      .o_busy       (busy[g]),
      .o_overflow   (overflow[g])
    );
  end

  // Round-robin: scan from r_rr_ptr, grant the first full hold. Space is
  // judged on the pre-pop count so a same-cycle pop never enables a push.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_push    = 1'b0;
    w_idx     = 0;
    w_space   = (r_count < (AW+1)'(DEPTH));
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (!w_push && w_space && w_req[w_idx]) begin
        w_push         = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_gnt_idx      = CH_W'(w_idx);
      end
    end
  end

  assign rec_valid = (r_count != '0);
  assign w_pop     = rec_valid && rec_ready;
  assign rec_data  = rec_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge ap_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_gnt_idx, w_hold_rec[w_gnt_idx]};
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= (w_gnt_idx == CH_W'(NUM_CH-1)) ? '0 : w_gnt_idx + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hls_perf_monitor.sv
// ============================================================================
// tb_hls_perf_monitor : directed checks of the transaction monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hls_perf_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, clear, rec_ready;
  logic [3:0]  start, done, cont, iter;
  logic        rec_valid;
  logic [34:0] rec_data;
  logic [63:0] txn_count;
  logic [3:0]  busy, overflow;

  logic        s_start, s_done, s_iter, s_ready, s_rec_valid;
  logic [9:0]  s_rec_data;
  logic [3:0]  s_txn;
  logic        s_busy, s_overflow;

  int total = 0;
  int bad   = 0;
  int exp_txn [4];

  always #5 clk = ~clk;

  hls_perf_monitor #(.NUM_CH(4), .CNT_W(16), .DEPTH(8)) u_dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .enable(enable), .clear(clear),
    .mon_start(start), .mon_done(done), .mon_continue(cont), .mon_iter(iter),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .txn_count(txn_count), .busy(busy), .overflow(overflow)
  );

  hls_perf_monitor #(.NUM_CH(1), .CNT_W(4), .DEPTH(2)) u_sat (
    .ap_clk(clk), .ap_rst_n(rst_n), .enable(1'b1), .clear(1'b0),
    .mon_start(s_start), .mon_done(s_done), .mon_continue(1'b1), .mon_iter(s_iter),
    .rec_valid(s_rec_valid), .rec_ready(s_ready), .rec_data(s_rec_data),
    .txn_count(s_txn), .busy(s_busy), .overflow(s_overflow)
  );

  typedef struct {
    int          ch;
    int          n;
    logic [31:0] mask;
    logic [15:0] exp_lat;
    logic [15:0] exp_iter;
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_txn_vec();
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < 4; c++) v[c*16 +: 16] = 16'(exp_txn[c]);
    return v;
  endfunction

  task automatic clear_exp();
    for (int c = 0; c < 4; c++) exp_txn[c] = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    clear_exp();
  endtask

  task automatic pop();
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
  endtask

  task automatic wait_rec();
    int c = 0;
    while (!rec_valid && c < 20) begin
      step();
      c++;
    end
    chk("rec_timeout", {63'd0, rec_valid}, 64'd1);
  endtask

  // start in the first cycle, done n cycles later; mask[k] is the iter strobe in cycle k
  task automatic run_txn(input int ch, input int n, input logic [31:0] mask);
    start[ch] = 1'b1;
    iter[ch]  = mask[0];
    done[ch]  = (n == 0);
    step();
    start[ch] = 1'b0;
    if (n > 0) chk("busy_rise", {63'd0, busy[ch]}, 64'd1);
    for (int k = 1; k <= n; k++) begin
      iter[ch] = mask[k];
      done[ch] = (k == n);
      step();
    end
    done[ch] = 1'b0;
    iter[ch] = 1'b0;
    exp_txn[ch]++;
  endtask

  initial begin
    int pops;

    vecs[0] = '{ch: 1, n: 0, mask: 32'h1,  exp_lat: 16'd1, exp_iter: 16'd1};
    vecs[1] = '{ch: 2, n: 3, mask: 32'h0,  exp_lat: 16'd4, exp_iter: 16'd0};
    vecs[2] = '{ch: 3, n: 1, mask: 32'h3,  exp_lat: 16'd2, exp_iter: 16'd2};
    vecs[3] = '{ch: 0, n: 5, mask: 32'h3F, exp_lat: 16'd6, exp_iter: 16'd6};
    vecs[4] = '{ch: 2, n: 2, mask: 32'h4,  exp_lat: 16'd3, exp_iter: 16'd1};

    rst_n = 1'b0; enable = 1'b1; clear = 1'b0; rec_ready = 1'b0;
    start = '0; done = '0; cont = 4'hF; iter = '0;
    s_start = 1'b0; s_done = 1'b0; s_iter = 1'b0; s_ready = 1'b0;
    clear_exp();
    repeat (3) step();
    chk("rst_valid", {63'd0, rec_valid}, 64'd0);
    chk("rst_data",  {29'd0, rec_data}, 64'd0);
    chk("rst_txn",   txn_count, 64'd0);
    chk("rst_busy",  {60'd0, busy}, 64'd0);
    chk("rst_ovf",   {60'd0, overflow}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) step();

    // single transaction: 8-cycle latency, 5 iteration strobes
    run_txn(0, 7, 32'b0101_0111);
    chk("t1_valid_early", {63'd0, rec_valid}, 64'd0);
    chk("t1_txn", txn_count, exp_txn_vec());
    step();
    chk("t1_valid", {63'd0, rec_valid}, 64'd1);
    chk("t1_rec", {29'd0, rec_data}, {29'd0, 2'd0, 16'd8, 16'd5, 1'b0});
    chk("t1_busy_fall", {60'd0, busy}, 64'd0);
    pop();
    chk("t1_empty", {63'd0, rec_valid}, 64'd0);

    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].ch, vecs[i].n, vecs[i].mask);
      wait_rec();
      chk("vec_rec", {29'd0, rec_data},
          {29'd0, 2'(vecs[i].ch), vecs[i].exp_lat, vecs[i].exp_iter, 1'b0});
      chk("vec_txn", txn_count, exp_txn_vec());
      pop();
    end

    // simultaneous completions on ch1 and ch3, arbiter pointer at 0
    do_clear();
    chk("clr_txn", txn_count, 64'd0);
    start = 4'b1010; step();
    start = 4'b0000; done = 4'b1010; step();
    done = 4'b0000; rec_ready = 1'b1;
    step();
    chk("rr_first", {62'd0, rec_data[34:33]}, 64'd1);
    step();
    chk("rr_second", {62'd0, rec_data[34:33]}, 64'd3);
    chk("rr_second_lat", {48'd0, rec_data[32:17]}, 64'd2);
    step();
    chk("rr_empty", {63'd0, rec_valid}, 64'd0);
    rec_ready = 1'b0;

    // fill FIFO and hold, then drop one record
    do_clear();
    for (int i = 0; i < 10; i++) begin
      run_txn(0, 1, 32'h0);
      if (i == 8) chk("ovf_before", {60'd0, overflow}, 64'd0);
    end
    chk("ovf_set", {60'd0, overflow}, 64'd1);
    chk("ovf_txn", txn_count, exp_txn_vec());
    rec_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 30; c++) begin
      if (rec_valid) begin
        chk("drain_rec", {29'd0, rec_data}, {29'd0, 2'd0, 16'd2, 16'd0, 1'b0});
        pops++;
      end
      step();
    end
    rec_ready = 1'b0;
    chk("drain_count", 64'(pops), 64'd9);
    chk("ovf_sticky", {60'd0, overflow}, 64'd1);
    do_clear();
    chk("ovf_clear", {60'd0, overflow}, 64'd0);

    // continue held low: WAIT_CONT ignores start
    cont[2] = 1'b0;
    run_txn(2, 1, 32'h0);
    chk("wc_busy", {63'd0, busy[2]}, 64'd1);
    start[2] = 1'b1; step(); step(); start[2] = 1'b0;
    chk("wc_busy_hold", {63'd0, busy[2]}, 64'd1);
    chk("wc_txn", txn_count, exp_txn_vec());
    cont[2] = 1'b1;
    step();
    chk("wc_idle", {63'd0, busy[2]}, 64'd0);
    run_txn(2, 2, 32'h0);
    chk("wc_txn2", txn_count, exp_txn_vec());
    rec_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      if (rec_valid) pops++;
      step();
    end
    rec_ready = 1'b0;
    chk("wc_records", 64'(pops), 64'd2);

    // done in IDLE, start while disabled, clear mid-transaction
    do_clear();
    done[1] = 1'b1; step(); done[1] = 1'b0;
    enable = 1'b0; start[0] = 1'b1; step(); start[0] = 1'b0; enable = 1'b1;
    chk("dis_busy", {60'd0, busy}, 64'd0);
    start[1] = 1'b1; step(); start[1] = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    done[1] = 1'b1; step(); done[1] = 1'b0;
    step(); step();
    chk("ign_txn", txn_count, 64'd0);
    chk("ign_valid", {63'd0, rec_valid}, 64'd0);
    // in-flight transaction completes after enable drops
    start[3] = 1'b1; step(); start[3] = 1'b0;
    enable = 1'b0; done[3] = 1'b1; step(); done[3] = 1'b0; enable = 1'b1;
    chk("dis_inflight", txn_count, {16'd1, 48'd0});
    do_clear();

    // 4-bit counters: saturation on both latency and iterations
    s_start = 1'b1; s_iter = 1'b1; step(); s_start = 1'b0;
    repeat (18) step();
    s_done = 1'b1; step(); s_done = 1'b0; s_iter = 1'b0;
    step();
    chk("sat_rec", {54'd0, s_rec_data}, {54'd0, 1'b0, 4'd15, 4'd15, 1'b1});
    s_ready = 1'b1; step(); s_ready = 1'b0;
    s_start = 1'b1; step(); s_start = 1'b0;
    repeat (13) step();
    s_done = 1'b1; step(); s_done = 1'b0;
    step();
    chk("sat_edge_rec", {54'd0, s_rec_data}, {54'd0, 1'b0, 4'd15, 4'd0, 1'b0});
    chk("sat_txn", {60'd0, s_txn}, 64'd2);

    // asynchronous reset mid-BUSY with records queued
    run_txn(0, 1, 32'h0);
    run_txn(1, 1, 32'h0);
    run_txn(2, 1, 32'h0);
    start[3] = 1'b1; step(); start[3] = 1'b0;
    step(); step();
    chk("pre_rst_valid", {63'd0, rec_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, rec_valid}, 64'd0);
    chk("arst_data",  {29'd0, rec_data}, 64'd0);
    chk("arst_txn",   txn_count, 64'd0);
    chk("arst_busy",  {60'd0, busy}, 64'd0);
    chk("arst_sat_valid", {63'd0, s_rec_valid}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step(); step(); step();
    chk("post_rst_valid", {63'd0, rec_valid}, 64'd0);
    chk("post_rst_busy",  {60'd0, busy}, 64'd0);
    chk("post_rst_txn",   txn_count, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
